adder_result_serializer: RTL
============================

# adder_result_serializer

Downstream stage of the cascaded wide `Adder_pipe` chain. It captures each wide result `{Cout, S}` on the adder's `out_valid` pulse, buffers up to `DEPTH` results, and streams each one out as `OUT_WIDTH`-bit beats on a valid/ready interface with a last-beat marker. The adder pipeline cannot be stalled, so results that arrive while the buffer is full are dropped and flagged with a sticky overflow bit.

## Interface
Parameters:
- `IN_WIDTH`, default 2048: width of the sum `S`. The serialized word is `IN_WIDTH+1` bits.
- `OUT_WIDTH`, default 128: beat width.
- `DEPTH`, default 2: result buffer entries. Must be a power of 2 and ≥1.
- Derived `NB = ceil((IN_WIDTH+1)/OUT_WIDTH)`: beats per result. With defaults, NB = 17.

Ports:
- `clk`  in  1  clock. Single clock domain.
- `resetn`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  result strobe; connects to the adder's `out_valid`.
- `S`  in  IN_WIDTH  sum from the adder.
- `Cout`  in  1  carry-out from the adder.
- `out_data`  out  OUT_WIDTH  current beat.
- `out_valid`  out  1  beat available.
- `out_ready`  in  1  consumer accepts the beat.
- `out_last`  out  1  current beat is beat NB-1 of its result.
- `overflow`  out  1  sticky: at least one result was dropped.
- `level`  out  `$clog2(DEPTH+1)`  number of buffered results, including the one currently streaming.

## Operation
- **Stored word.** Each entry holds `P = {Cout, S}`, zero-extended to `NB*OUT_WIDTH` bits.
- **Beat order.** Beat `k` is `P[k*OUT_WIDTH +: OUT_WIDTH]` (LSB first, default).
- **Write.** On `in_valid`, `P` is written at the write pointer. The pointer increments modulo DEPTH.
- **Drop.** If `level==DEPTH` and no pop occurs in the same cycle, the result is dropped and `overflow` is set. `overflow` clears only on reset.
- **Pop.** A pop is a transfer (`out_valid && out_ready`) while `out_last=1`.
- **Full plus pop.** If the buffer is full and a pop occurs in the same cycle as `in_valid`, the write is accepted. `level` stays at DEPTH and `overflow` does not change.
- **Beat counter.**
  - Increments on each transfer.
  - Wraps to 0 after beat NB-1.
  - On wrap, the read pointer increments modulo DEPTH.
- **Level.** `level` is +1 on an accepted write, -1 on a pop, and unchanged when both happen in the same cycle.
- **Output qualification.** `out_valid = (level != 0)`. `out_data` and `out_last` are 0 whenever `out_valid=0`.
- **States.**
  - IDLE: `level=0`.
  - STREAM: `level>0`.
  - IDLE→STREAM on an accepted write.
  - STREAM→IDLE on a pop with `level==1` and no simultaneous write.

## Timing
- **Reset.** While `resetn=0`, asynchronously:
  - `out_valid=0`, `out_last=0`, `out_data=0`, `level=0`, `overflow=0`.
  - Pointers and beat counter are cleared.
  - Reset mid-stream discards all buffered results and any partially sent result. No beats appear after release until a new `in_valid`.
- **Latency.** A result sampled at edge t drives its beat 0 with `out_valid=1` in the cycle after edge t, when the buffer was empty.
- **Throughput.** With `out_ready` held at 1, a result takes NB consecutive cycles. Back-to-back `in_valid` bursts longer than `DEPTH + floor((burst span)/NB)` overflow.
- **Handshake rules.**
  - `out_data` and `out_last` are stable while `out_valid && !out_ready`.
  - `out_valid` never drops without a transfer, except on reset.
  - `out_ready` may depend combinationally on `out_valid`.
- **Register boundaries.** `level`, `overflow` and pointers are registered. `out_data` is a mux of registered state only; there is no combinational path from `in_valid`.

## Configuration
- **`ADDER_SER_MSB_FIRST_EN`**
  - Defined: beat `k` is `P[(NB-1-k)*OUT_WIDTH +: OUT_WIDTH]`. The padded top beat, containing `Cout`, is sent first, and `out_last` marks the lowest beat.
  - Undefined: LSB-first order, as described under Operation.
  - All other behaviour is identical in both cases.

## Test plan
Bench parameters: `IN_WIDTH=256`, `OUT_WIDTH=64`, `DEPTH=2`, which gives NB=5.
- **Reset values.** Hold `resetn=0` with `in_valid=1` → `out_valid=0`, `out_data=0`, `level=0`, `overflow=0` throughout.
- **Single result, no backpressure.**
  - Stimulus: one-cycle `in_valid` with `S={64'h4444…44, 64'h3333…33, 64'h2222…22, 64'h1111…11}`, `Cout=1`, `out_ready=1`.
  - Response: next cycle onward, 5 beats `1111…`, `2222…`, `3333…`, `4444…`, `64'h1`. `out_last` is high only on the 5th. `level` returns to 0.
- **Backpressure.** Same stimulus with `out_ready` toggling 1,0,0,1,… → identical beat sequence; `out_data` is held during every stall cycle.
- **Overflow.** `out_ready=0`, three `in_valid` pulses carrying distinct results R0, R1, R2 → `level=2`, `overflow=1`. Raising `out_ready` then yields exactly R0 followed by R1 (10 beats), and `overflow` stays 1.
- **Simultaneous write and pop.** Buffer full, `in_valid` asserted in the same cycle as the final beat of the head result transfers → new result accepted, `level` stays 2, `overflow=0`. Full drain delivers all three results in order.
- **MSB-first macro.** Build with `ADDER_SER_MSB_FIRST_EN` and repeat the single-result test → beats `64'h1`, `4444…`, `3333…`, `2222…`, `1111…`, with `out_last` on `1111…`.

Source files
------------

// File: rtl/adder_result_serializer.sv
// Buffers wide {Cout, S} adder results and streams each one out as OUT_WIDTH-bit beats.
// Define ADDER_SER_MSB_FIRST_EN to send the most significant beat of each result first.
module adder_result_serializer #(
  parameter int IN_WIDTH  = 2048,
  parameter int OUT_WIDTH = 128,
  parameter int DEPTH     = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         in_valid,
  input  logic [IN_WIDTH-1:0]          S,
  input  logic                         Cout,
  output logic [OUT_WIDTH-1:0]         out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         overflow,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int NB   = (IN_WIDTH + OUT_WIDTH) / OUT_WIDTH;
  localparam int PW   = NB * OUT_WIDTH;
  localparam int LW   = $clog2(DEPTH + 1);
  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW   = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [PTRW-1:0] PTR_MASK   = PTRW'(DEPTH - 1);
  localparam logic [BW-1:0]   LAST_BEAT  = BW'(NB - 1);
  localparam logic [LW-1:0]   FULL_LEVEL = LW'(DEPTH);
  localparam logic [LW-1:0]   ONE_LEVEL  = LW'(1);

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } state_t;

  state_t              state_reg, state_next;
  logic [LW-1:0]       level_reg, level_next;
  logic                overflow_reg, overflow_next;
  logic [PTRW-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [PTRW-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [BW-1:0]       beat_reg, beat_next;
  logic                last_reg, last_next;

  logic [PW-1:0]        mem [DEPTH];
  logic [PW-1:0]        in_word;
  logic [PW-1:0]        head_word;
  logic [OUT_WIDTH-1:0] beats [NB];
  logic [BW-1:0]        beat_sel;

  logic xfer;
  logic pop;
  logic full;
  logic accept;

  assign in_word   = PW'({Cout, S});
  assign head_word = mem[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_beat
      assign beats[gi] = head_word[gi*OUT_WIDTH +: OUT_WIDTH];
    end
  endgenerate

`ifdef ADDER_SER_MSB_FIRST_EN
  assign beat_sel = BW'(LAST_BEAT - beat_reg);
`else
  assign beat_sel = beat_reg;
`endif

  // Outputs are driven only from registered state, never from in_valid.
  assign out_valid = (state_reg == ST_STREAM);
  assign out_last  = last_reg;
  assign out_data  = out_valid ? beats[beat_sel] : '0;
  assign overflow  = overflow_reg;
  assign level     = level_reg;

  always_comb begin
    xfer          = out_valid && out_ready;
    pop           = xfer && (beat_reg == LAST_BEAT);
    full          = (level_reg == FULL_LEVEL);
    // A full buffer still takes a write when the head result leaves in the same cycle.
    accept        = in_valid && (!full || pop);

    level_next    = level_reg;
    overflow_next = overflow_reg | (in_valid & ~accept);
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    beat_next     = beat_reg;
    state_next    = state_reg;

    if (accept && !pop) begin
      level_next = level_reg + ONE_LEVEL;
    end else if (pop && !accept) begin
      level_next = level_reg - ONE_LEVEL;
    end

    if (accept) begin
      wr_ptr_next = PTRW'(wr_ptr_reg + 1'b1) & PTR_MASK;
    end
    if (pop) begin
      rd_ptr_next = PTRW'(rd_ptr_reg + 1'b1) & PTR_MASK;
    end

    if (xfer) begin
      beat_next = (beat_reg == LAST_BEAT) ? '0 : BW'(beat_reg + 1'b1);
    end

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (pop && !accept && (level_reg == ONE_LEVEL)) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    last_next = (state_next == ST_STREAM) && (beat_next == LAST_BEAT);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= ST_IDLE;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      beat_reg     <= '0;
      last_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      level_reg    <= level_next;
      overflow_reg <= overflow_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      beat_reg     <= beat_next;
      last_reg     <= last_next;
    end
  end

  // Storage carries no reset; out_data is gated by out_valid instead.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr_reg] <= in_word;
    end
  end

endmodule
